// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder/subtractor that walks a W-bit operand pair
// CW bits per clock, keeping the inter-chunk carry in a register so the
// combinational carry chain is only CW bits long.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The input side is ready only in IDLE; the
// output side holds out_valid, s, cout (and ovf) steady until out_ready.
//
// Optional feature macro: OVF_FLAG_EN adds the ovf port and the MSB-carry
// tracking that produces the two's-complement overflow flag.
//
// The FSM state is kept in the typed signal state_q (state_e) so checkers
// can bind to it directly.
module chunked_adder #(
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout
`ifdef OVF_FLAG_EN
  ,
  output logic         ovf
`endif
);

  // Number of chunks and the width of the chunk index.
  localparam int N  = W / CW;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  // Reject illegal geometries at elaboration time.
  if (W < 1 || CW < 1 || (W % CW) != 0) begin : g_param_check
    $error("chunked_adder: W must be >= 1 and a multiple of CW");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Captured operands. b_q already holds ~b for subtraction, and the
  // initial carry is 1 in that case, so RUN never needs to know the mode.
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  s_q, s_d;
  logic          cout_q, cout_d;
`ifdef OVF_FLAG_EN
  logic          ovf_q, ovf_d;
  logic          msb_carry_in;
`endif

  logic          accept;
  logic          last_chunk;
  logic [CW-1:0] a_chunk;
  logic [CW-1:0] b_chunk;
  logic [CW:0]   chunk_sum;

  assign accept     = in_valid && in_ready;
  assign last_chunk = (k_q == KW'(N - 1));
  assign a_chunk    = a_q[k_q*CW +: CW];
  assign b_chunk    = b_q[k_q*CW +: CW];
  assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CW{1'b0}}, carry_q};

`ifdef OVF_FLAG_EN
  // Carry into the top bit of the chunk: a ^ b ^ sum at that bit position.
  // On the last chunk this is the carry into the operand MSB.
  assign msb_carry_in = a_chunk[CW-1] ^ b_chunk[CW-1] ^ chunk_sum[CW-1];
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)     state_d = ST_RUN;
      ST_RUN:  if (last_chunk) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake flags decoded from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath next-state: capture on accept, add one chunk per RUN cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        // Chunks above k keep their old value until their turn comes.
        s_d[k_q*CW +: CW] = chunk_sum[CW-1:0];
        carry_d           = chunk_sum[CW];
        if (last_chunk) begin
          k_d    = '0;
          cout_d = chunk_sum[CW];
`ifdef OVF_FLAG_EN
          ovf_d  = msb_carry_in ^ chunk_sum[CW];
`endif
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: begin
        // DONE: result registers hold while the consumer stalls.
      end
    endcase
  end

  // Datapath registers; reset clears everything and drops any in-flight op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
`ifdef OVF_FLAG_EN
  assign ovf  = ovf_q;
`endif

  // Input and output sides are never ready/valid at the same time.
  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid));

  // A stalled result stays put until the consumer takes it.
  a_hold_result: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(s) && $stable(cout)));

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (W=16, CW=4): a table of directed
// vectors, hand-written back-pressure and mid-run reset sequences, and
// randomized operations scored against an arithmetic reference model.
module tb_chunked_adder;

  localparam int W   = 16;
  localparam int CW  = 4;
  localparam int N   = W / CW;
  localparam int LAT = N;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         cout;
`ifdef OVF_FLAG_EN
  logic         ovf;
`endif

  chunked_adder #(.W(W), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .cout     (cout)
`ifdef OVF_FLAG_EN
    ,
    .ovf      (ovf)
`endif
  );

  // Scoreboard: expected {ovf, cout, s} per accepted operation.
  logic [W+1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: plain integer arithmetic on the operation's meaning.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                         input logic tc, input logic ts);
    int unsigned ua, ub, ur;
    int sa, sb, sr;
    logic [W-1:0] rs;
    logic rc, ro;
    ua = int'(ta);
    ub = int'(tb);
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    if (!ts) begin
      ur = ua + ub + int'(tc);
      rs = ur[W-1:0];
      rc = (ur >= (1 << W));
      sr = sa + sb + int'(tc);
    end else begin
      ur = ua - ub;
      rs = ur[W-1:0];
      rc = (ua >= ub);
      sr = sa - sb;
    end
    ro = (sr > ((1 << (W-1)) - 1)) || (sr < -(1 << (W-1)));
    return {ro, rc, rs};
  endfunction

  // Driver: present one operation and complete the accept edge.
  // Inputs are scrambled right after the edge; the DUT must ignore that.
  task automatic accept_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input logic ts);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk("in_ready_low_in_run", 32'(in_ready), 32'd0);
  endtask

  // Count edges from the accept edge until out_valid shows up (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic check_result(input string nm);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      chk({nm, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, "_s"}, 32'(s), 32'(e[W-1:0]));
    chk({nm, "_cout"}, 32'(cout), 32'(e[W]));
`ifdef OVF_FLAG_EN
    chk({nm, "_ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
  endtask

  // Consumer takes the result; block must be ready on the following cycle.
  task automatic release_out(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({nm, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] hold_s;
    logic hold_c;

    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[5]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[6]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[8]  = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[11] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[12] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef OVF_FLAG_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back({vecs[i].ovf, vecs[i].cout, vecs[i].s});
      accept_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_result(lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check_result($sformatf("vec%0d", i));
      release_out($sformatf("vec%0d", i));
    end

    // Back-pressure: result held for 5 cycles, new in_valid ignored.
    exp_q.push_back(model(16'h1234, 16'h4321, 1'b0, 1'b0));
    accept_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_result(lat);
    chk("bp_latency", 32'(lat), 32'(LAT));
    hold_s = s;
    hold_c = cout;
    check_result("bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c == 2);
      a = 16'hAAAA; b = 16'h1111; sub = 1'b0; cin = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d_s_hold", c), 32'(s), 32'(hold_s));
      chk($sformatf("bp%0d_cout_hold", c), 32'(cout), 32'(hold_c));
    end
    release_out("bp");
    @(posedge clk);
    #1;
    chk("bp_pulse_not_taken", 32'(in_ready), 32'd1);

    // Reset while k=2 in RUN discards the operation.
    accept_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_s", 32'(s), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    exp_q.push_back({1'b0, 1'b0, 16'h1000});
    accept_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_result(lat);
    chk("post_rst_latency", 32'(lat), 32'(LAT));
    check_result("post_rst");
    release_out("post_rst");

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rsb;
      int dly;
      ra  = W'($urandom);
      rb  = W'($urandom);
      if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 1) ? 16'h7FFF : 16'h8000);
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 1) ? 16'hFFFF : 16'h0001);
      rc  = 1'($urandom);
      rsb = 1'($urandom);
      exp_q.push_back(model(ra, rb, rc, rsb));
      accept_op(ra, rb, rc, rsb);
      wait_result(lat);
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(LAT));
      check_result($sformatf("rnd%0d", i));
      dly = $urandom_range(0, 3);
      repeat (dly) @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_still_valid", i), 32'(out_valid), 32'd1);
      release_out($sformatf("rnd%0d", i));
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
Parametrised multi-cycle adder/subtractor that processes a W-bit operand pair CW bits per clock.
- Inter-chunk carry is held in a register.
- Trades latency for a short carry chain.
- Valid/ready handshakes on input and output, so it drops into streaming datapaths.
- Successor to the combinational ripple adders in the arithmetic library.

Parameters:
- W, 16, operand/result width in bits; W >= 1.
- CW, 4, chunk width processed per cycle; W % CW == 0 required, else elaboration error. N = W/CW chunks.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands/mode present
- in_ready  output  1  block can accept an operation
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry-in (ignored when sub=1)
- sub  input  1  0: a+b+cin; 1: a-b
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- s  output  W  sum/difference
- cout  output  1  carry out of MSB (sub=1: 1 = no borrow)
- ovf  output  1  signed overflow (only with OVF_FLAG_EN)

Behaviour:
- Reset: rst_n=0 sampled at a clk edge forces state IDLE.
  - in_ready=1, out_valid=0, s=0, cout=0, ovf=0.
  - Internal chunk index, carry and operand registers cleared.
  - Reset overrides any in-flight operation; that operation is discarded.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid&&in_ready: capture a, sub?~b:b, carry=sub?1:cin, sub flag. Index k=0. Go to RUN.
  - RUN: in_ready=0, out_valid=0.
    - Each cycle: {c, s[k*CW+:CW]} = a_chunk(k) + b_chunk(k) + carry; carry <= c; k <= k+1.
    - On the cycle processing k=N-1: cout <= c; go to DONE.
  - DONE: out_valid=1; s and cout stable.
    - On out_ready=1: go to IDLE.
- Latency: N clock edges from the accept edge to out_valid=1, e.g. W=16, CW=4 gives 4. CW=W gives N=1.
- Throughput: one operation per N+2 cycles minimum. No overlap: in_ready is low in RUN and DONE, and in_valid is ignored there.
- Inputs a, b, cin and sub are sampled only at the accept edge; later changes have no effect.
- Result bits of chunks not yet computed hold their previous values. They are not observable because out_valid=0.
- Output back-pressure: DONE is held indefinitely while out_ready=0. s, cout and ovf are unchanged.
- out_ready while not in DONE has no effect.
- Arithmetic is modulo 2^W. No saturation.

Optional Feature:
- Macro: OVF_FLAG_EN.
- Defined:
  - ovf port exists.
  - In the final RUN cycle, ovf <= carry into MSB XOR carry out of MSB, i.e. two's-complement overflow of the effective operation.
  - ovf is valid with out_valid and held like s.
- Undefined:
  - Port ovf is absent.
  - No MSB-carry tracking logic is built.

Test Plan (W=16, CW=4):
- a=0x1234, b=0x4321, cin=0, sub=0 -> s=0x5555, cout=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> s=0x0000, cout=1 (carry ripples across all chunk registers). a=0x0000, b=0x0000, cin=1 -> s=0x0001, cout=0.
- sub=1, a=0x0005, b=0x0007 -> s=0xFFFE, cout=0. sub=1, a=0x0007, b=0x0005, cin=0 -> s=0x0002, cout=1 (cin ignored).
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid=1, s/cout constant, in_ready=0. A new in_valid pulse meanwhile is not accepted. After out_ready=1, in_ready=1 the next cycle.
- Assert rst_n=0 for one cycle while k=2 in RUN -> next cycle in_ready=1, out_valid=0, s=0, cout=0. A following 0x0F0F+0x00F1 gives s=0x1000, cout=0.
- OVF_FLAG_EN: 0x7FFF+0x0001 -> s=0x8000, ovf=1. sub=1, 0x8000-0x0001 -> s=0x7FFF, ovf=1. 0x0001+0x0001 -> ovf=0.
